fp_sqrt_d_wb: RTL and testbench

- Writeback stage directly downstream of the combinational double-precision square-root datapath.
- Captures the operand, the raw sqrt result and the destination tag, and applies RISC-V D-extension result fix-ups (canonical NaN, signed zero).
- Generates per-op exception flags, buffers results in a 2-entry FIFO with valid/ready on both sides, and accumulates sticky fflags on commit.

---
 rtl/fp_sqrt_d_wb.sv | 147 ++++++++++++++
 tb/tb_fp_sqrt_d_wb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_d_wb.sv
// Writeback stage for the double-precision sqrt datapath: RISC-V result fix-ups,
// per-op flags, a 2-entry valid/ready FIFO and sticky fflags. Optional counters: FP_SQRT_WB_STATS_EN.
module fp_sqrt_d_wb #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_sqrt,
  input  logic             in_inexact,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags,
  output logic [4:0]       fflags,
  input  logic             fflags_clr
`ifdef FP_SQRT_WB_STATS_EN
  ,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_nv
`endif
);

  localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] NEG_ZERO  = 64'h8000_0000_0000_0000;

  logic [63:0]      res_mem [2];
  logic [TAG_W-1:0] tag_mem [2];
  logic [4:0]       flg_mem [2];
  logic             wptr;
  logic             rptr;
  logic [1:0]       count;

  logic             push;
  logic             pop;

  logic [10:0]      a_exp;
  logic [51:0]      a_frac;
  logic             a_sign;
  logic             a_nan;
  logic             a_snan;
  logic             a_mag_zero;
  logic             a_inf;
  logic [63:0]      fix_result;
  logic [4:0]       fix_flags;

  // in_ready depends only on the registered count, so out_ready never reaches it
  assign in_ready  = (count != 2'(DEPTH));
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_result = res_mem[rptr];
  assign out_tag    = tag_mem[rptr];
  assign out_flags  = flg_mem[rptr];

  assign a_sign     = in_a[63];
  assign a_exp      = in_a[62:52];
  assign a_frac     = in_a[51:0];
  assign a_nan      = (a_exp == 11'h7FF) && (a_frac != 52'd0);
  assign a_snan     = a_nan && !a_frac[51];
  assign a_mag_zero = (in_a[62:0] == 63'd0);
  assign a_inf      = (a_exp == 11'h7FF) && (a_frac == 52'd0);

  // Flags are laid out {NV,DZ,OF,UF,NX}; DZ/OF/UF can never be raised by sqrt
  always_comb begin
    fix_result = in_sqrt;
    fix_flags  = {4'b0000, in_inexact};
    if (a_snan) begin
      fix_result = CANON_NAN;
      fix_flags  = 5'b10000;
    end else if (a_nan) begin
      fix_result = CANON_NAN;
      fix_flags  = 5'b00000;
    end else if (in_a == NEG_ZERO) begin
      fix_result = NEG_ZERO;
      fix_flags  = 5'b00000;
    end else if (a_sign) begin
      fix_result = CANON_NAN;
      fix_flags  = 5'b10000;
    end else if (a_mag_zero || a_inf) begin
      fix_result = in_a;
      fix_flags  = 5'b00000;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        res_mem[i] <= '0;
        tag_mem[i] <= '0;
        flg_mem[i] <= '0;
      end
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        res_mem[wptr] <= fix_result;
        tag_mem[wptr] <= in_tag;
        flg_mem[wptr] <= fix_flags;
        wptr          <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // A clear coinciding with a pop keeps the popped op's flags
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags <= 5'b00000;
    end else if (fflags_clr && pop) begin
      fflags <= out_flags;
    end else if (fflags_clr) begin
      fflags <= 5'b00000;
    end else if (pop) begin
      fflags <= fflags | out_flags;
    end
  end

`ifdef FP_SQRT_WB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= 32'd0;
      stat_nv  <= 32'd0;
    end else if (pop) begin
      stat_ops <= stat_ops + 32'd1;
      if (out_flags[4]) begin
        stat_nv <= stat_nv + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_sqrt_d_wb.sv
// Directed self-checking bench for fp_sqrt_d_wb: fix-ups, flags, FIFO backpressure,
// sticky fflags and reset. Inputs change 1ns after posedge; outputs are sampled there too.
module tb_fp_sqrt_d_wb;

  localparam int TAG_W = 5;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_a;
  logic [63:0]      in_sqrt;
  logic             in_inexact;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_flags;
  logic [4:0]       fflags;
  logic             fflags_clr;
`ifdef FP_SQRT_WB_STATS_EN
  logic [31:0]      stat_ops;
  logic [31:0]      stat_nv;
`endif

  int checks = 0;
  int errors = 0;

  fp_sqrt_d_wb #(.TAG_W(TAG_W), .DEPTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_sqrt    (in_sqrt),
    .in_inexact (in_inexact),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
`ifdef FP_SQRT_WB_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_nv    (stat_nv)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] s,
                               input logic inexact, input logic [TAG_W-1:0] tag);
    in_valid   = 1'b1;
    in_a       = a;
    in_sqrt    = s;
    in_inexact = inexact;
    in_tag     = tag;
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] s;
    logic        nx;
    logic [63:0] exp_res;
    logic [4:0]  exp_flg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{64'h7FF8_0000_0000_0001, 64'h1234, 1'b1, 64'h7FF8_0000_0000_0000, 5'b00000}; // qNaN
    vecs[1] = '{64'h7FF0_0000_0000_0000, 64'h1234, 1'b1, 64'h7FF0_0000_0000_0000, 5'b00000}; // +inf
    vecs[2] = '{64'h0000_0000_0000_0000, 64'h1234, 1'b1, 64'h0000_0000_0000_0000, 5'b00000}; // +0
    vecs[3] = '{64'hFFF0_0000_0000_0000, 64'h1234, 1'b0, 64'h7FF8_0000_0000_0000, 5'b10000}; // -inf
    vecs[4] = '{64'h4000_0000_0000_0000, 64'h3FF6_A09E_667F_3BCD, 1'b1, 64'h3FF6_A09E_667F_3BCD, 5'b00001};
    vecs[5] = '{64'h8000_0000_0000_0001, 64'h1234, 1'b0, 64'h7FF8_0000_0000_0000, 5'b10000}; // -denormal
    vecs[6] = '{64'hFFF8_0000_0000_0000, 64'h1234, 1'b0, 64'h7FF8_0000_0000_0000, 5'b00000}; // -qNaN
    vecs[7] = '{64'hFFF0_0000_0000_0001, 64'h1234, 1'b0, 64'h7FF8_0000_0000_0000, 5'b10000}; // -sNaN

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_sqrt = '0; in_inexact = 1'b0;
    in_tag = '0; out_ready = 1'b0; fflags_clr = 1'b0;
    step(); step();
    rst = 1'b0;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_result", out_result, 64'd0);
    checkOutput("rst_tag", 64'(out_tag), 64'd0);
    checkOutput("rst_flags", 64'(out_flags), 64'd0);
    checkOutput("rst_fflags", 64'(fflags), 64'd0);
`ifdef FP_SQRT_WB_STATS_EN
    checkOutput("rst_stat_ops", 64'(stat_ops), 64'd0);
`endif

    // sqrt(4.0) = 2.0, one-cycle latency
    out_ready = 1'b1;
    applyStimulus(64'h4010_0000_0000_0000, 64'h4000_0000_0000_0000, 1'b0, 5'd3);
    step();
    in_valid = 1'b0;
    checkOutput("t1_valid", 64'(out_valid), 64'd1);
    checkOutput("t1_result", out_result, 64'h4000_0000_0000_0000);
    checkOutput("t1_tag", 64'(out_tag), 64'd3);
    checkOutput("t1_flags", 64'(out_flags), 64'd0);
    step();
    checkOutput("t1_drained", 64'(out_valid), 64'd0);
    checkOutput("t1_fflags", 64'(fflags), 64'd0);

    // sqrt(-2.0): invalid, held while out_ready low
    out_ready = 1'b0;
    applyStimulus(64'hC000_0000_0000_0000, 64'h1234, 1'b1, 5'd4);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("t2_result", out_result, 64'h7FF8_0000_0000_0000);
    checkOutput("t2_flags", 64'(out_flags), 64'h10);
    checkOutput("t2_fflags_before", 64'(fflags), 64'd0);
    out_ready = 1'b1;
    step();
    checkOutput("t2_fflags_after", 64'(fflags), 64'h10);
    checkOutput("t2_drained", 64'(out_valid), 64'd0);
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    checkOutput("t2_clr", 64'(fflags), 64'd0);

    // sNaN then -0, buffered
    out_ready = 1'b0;
    applyStimulus(64'h7FF0_0000_0000_0001, 64'h1234, 1'b0, 5'd5);
    step();
    applyStimulus(64'h8000_0000_0000_0000, 64'h1234, 1'b1, 5'd6);
    step();
    in_valid = 1'b0;
    checkOutput("t3_full", 64'(in_ready), 64'd0);
    checkOutput("t3_snan_res", out_result, 64'h7FF8_0000_0000_0000);
    checkOutput("t3_snan_flags", 64'(out_flags), 64'h10);
    checkOutput("t3_snan_tag", 64'(out_tag), 64'd5);
    out_ready = 1'b1;
    step();
    checkOutput("t3_nz_res", out_result, 64'h8000_0000_0000_0000);
    checkOutput("t3_nz_flags", 64'(out_flags), 64'd0);
    checkOutput("t3_nz_tag", 64'(out_tag), 64'd6);
    checkOutput("t3_fflags", 64'(fflags), 64'h10);
    step();
    checkOutput("t3_drained", 64'(out_valid), 64'd0);

    // Remaining fix-up classes
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].s, vecs[i].nx, 5'(i + 16));
      step();
      in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_res", i), out_result, vecs[i].exp_res);
      checkOutput($sformatf("vec%0d_flags", i), 64'(out_flags), 64'(vecs[i].exp_flg));
      checkOutput($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(i + 16));
      step();
    end
    checkOutput("vec_fflags", 64'(fflags), 64'h11);

    // Backpressure: third op held until space frees, order preserved
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    out_ready = 1'b0;
    applyStimulus(64'h4010_0000_0000_0000, 64'hA, 1'b0, 5'd10);
    step();
    checkOutput("bp_ready1", 64'(in_ready), 64'd1);
    applyStimulus(64'h4010_0000_0000_0000, 64'hB, 1'b0, 5'd11);
    step();
    checkOutput("bp_ready2", 64'(in_ready), 64'd0);
    applyStimulus(64'h4010_0000_0000_0000, 64'hC, 1'b0, 5'd12);
    step();
    checkOutput("bp_ready3", 64'(in_ready), 64'd0);
    checkOutput("bp_head_tag", 64'(out_tag), 64'd10);
    out_ready = 1'b1;
    step();
    checkOutput("bp_tag11", 64'(out_tag), 64'd11);
    checkOutput("bp_res11", out_result, 64'hB);
    checkOutput("bp_ready_open", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    checkOutput("bp_tag12", 64'(out_tag), 64'd12);
    checkOutput("bp_res12", out_result, 64'hC);
    checkOutput("bp_valid12", 64'(out_valid), 64'd1);
    step();
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    // Sticky NX, then clear coinciding with an NV pop
    applyStimulus(64'h4000_0000_0000_0000, 64'h3FF6_A09E_667F_3BCD, 1'b1, 5'd7);
    step();
    in_valid = 1'b0;
    step();
    checkOutput("st_nx", 64'(fflags), 64'h01);
    out_ready = 1'b0;
    applyStimulus(64'hC000_0000_0000_0000, 64'h1234, 1'b0, 5'd8);
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    fflags_clr = 1'b1;
    step();
    fflags_clr = 1'b0;
    checkOutput("st_clr_pop", 64'(fflags), 64'h10);

    // Reset with two entries buffered
    out_ready = 1'b0;
    applyStimulus(64'h4010_0000_0000_0000, 64'hD, 1'b1, 5'd13);
    step();
    applyStimulus(64'h4010_0000_0000_0000, 64'hE, 1'b1, 5'd14);
    step();
    in_valid = 1'b0;
    checkOutput("rr_full", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rr_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rr_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rr_fflags", 64'(fflags), 64'd0);
    checkOutput("rr_result", out_result, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
